// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin arbiter sharing one single-port 256x8 memory
// between NREQ engines. It issues at most one access per cycle, can lock
// ownership for atomic read-modify-write sequences, and flags reads with a
// one-hot rvalid RD_LAT cycles after their grant.
module s_mem_arbiter #(
    parameter int NREQ     = 3,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*8-1:0] addr,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [7:0]        rdata,
    output logic [7:0]        mem_address,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    input  logic [7:0]        mem_q,
    output logic              lock_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   lock_cnt_q;
    logic               lock_err_q;
    logic               blocked_q [NREQ];
    logic [NREQ-1:0]    rd_pipe_q [RD_LAT];

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [NREQ-1:0]    gnt_c;
    logic               force_rel;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant decode: free arbitration in IDLE, owner-only while OWNED.
    // A dropped lock ends ownership without a grant in that cycle.
    always_comb begin
        gnt_c = '0;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                if (pick_valid) gnt_c[pick_idx] = 1'b1;
            end else if (lock[owner_q] && req[owner_q]) begin
                gnt_c[owner_q] = 1'b1;
            end
        end
    end

    // The last OWNED cycle the owner is allowed before being evicted.
    assign force_rel = (state_q == ST_OWNED) && lock[owner_q] &&
                       (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

    // Memory port mux driven by the one-hot grant; idle port reads as zero.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_c[k]) begin
                mem_address = addr[8*k +: 8];
                mem_data    = wdata[8*k +: 8];
                mem_wren    = we[k];
            end
        end
    end

    // Arbitration FSM: round-robin pointer, lock ownership and hold timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        rr_ptr_q <= IDX_W'((int'(pick_idx) + 1) % NREQ);
                        if (lock[pick_idx] && !blocked_q[pick_idx]) begin
                            state_q    <= ST_OWNED;
                            owner_q    <= pick_idx;
                            lock_cnt_q <= '0;
                        end
                    end
                end
                ST_OWNED: begin
                    if (!lock[owner_q]) begin
                        state_q    <= ST_IDLE;
                        lock_cnt_q <= '0;
                    end else if (force_rel) begin
                        state_q    <= ST_IDLE;
                        lock_cnt_q <= '0;
                        lock_err_q <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Per-requester re-lock ban after eviction; cleared once lock is released.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_block
            always_ff @(posedge clk) begin
                if (reset)
                    blocked_q[gi] <= 1'b0;
                else if (force_rel && (owner_q == IDX_W'(gi)))
                    blocked_q[gi] <= 1'b1;
                else if (!lock[gi])
                    blocked_q[gi] <= 1'b0;
            end
        end
    endgenerate

    // Read-tracking pipe entry: one-hot id of a granted read.
    always_ff @(posedge clk) begin
        if (reset)
            rd_pipe_q[0] <= '0;
        else
            rd_pipe_q[0] <= gnt_c & ~we;
    end

    // Remaining read-latency stages.
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_rd_stage
            always_ff @(posedge clk) begin
                if (reset)
                    rd_pipe_q[gi] <= '0;
                else
                    rd_pipe_q[gi] <= rd_pipe_q[gi-1];
            end
        end
    endgenerate

    assign gnt      = gnt_c;
    assign rvalid   = rd_pipe_q[RD_LAT-1] & {NREQ{~reset}};
    assign rdata    = mem_q;
    assign lock_err = lock_err_q & ~reset;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: directed scenarios with literal expectations plus
// a per-cycle behavioural model of arbitration, locking and read returns.
module tb_s_mem_arbiter;

    localparam int NREQ     = 3;
    localparam int RD_LAT   = 1;
    localparam int LOCK_MAX = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req, lock, we;
    logic [NREQ*8-1:0] addr, wdata;
    logic [NREQ-1:0]   gnt, rvalid;
    logic [7:0]        rdata, mem_address, mem_data, mem_q;
    logic              mem_wren, lock_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] smem    [256];
    logic [7:0] ref_mem [256];

    s_mem_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read.
    always @(posedge clk) begin
        if (mem_wren) smem[mem_address] <= mem_data;
        mem_q <= smem[mem_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, evaluated every negedge ----------
    int              cyc = 0;
    int              m_rr = 0;
    int              m_owner = -1;
    int              m_held = 0;
    int              g;
    bit              m_banned [NREQ];
    bit              m_err;
    logic [NREQ-1:0] rv_tab [16];
    logic [7:0]      rd_tab [16];
    logic [NREQ-1:0] e_gnt, e_rv;
    logic [7:0]      e_addr, e_data, e_rd;
    logic            e_wren;

    initial begin
        m_err = 1'b0;
        for (int s = 0; s < 16; s++) begin rv_tab[s] = '0; rd_tab[s] = '0; end
        for (int k = 0; k < NREQ; k++) m_banned[k] = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("m_gnt_rst", gnt, 0);
                chk("m_wren_rst", mem_wren, 0);
                chk("m_addr_rst", mem_address, 0);
                chk("m_data_rst", mem_data, 0);
                chk("m_rvalid_rst", rvalid, 0);
                chk("m_lockerr_rst", lock_err, 0);
                m_rr = 0; m_owner = -1; m_held = 0; m_err = 1'b0;
                for (int k = 0; k < NREQ; k++) m_banned[k] = 1'b0;
                for (int s = 0; s < 16; s++) rv_tab[s] = '0;
            end else begin
                e_rv = rv_tab[cyc % 16];
                e_rd = rd_tab[cyc % 16];
                rv_tab[cyc % 16] = '0;
                g = -1;
                if (m_owner < 0) begin
                    for (int d = 0; d < NREQ; d++)
                        if (g < 0 && req[(m_rr + d) % NREQ]) g = (m_rr + d) % NREQ;
                end else if (req[m_owner] && lock[m_owner]) begin
                    g = m_owner;
                end
                e_gnt = '0; e_wren = 1'b0; e_addr = '0; e_data = '0;
                if (g >= 0) begin
                    e_gnt[g] = 1'b1;
                    e_wren   = we[g];
                    e_addr   = addr[8*g +: 8];
                    e_data   = wdata[8*g +: 8];
                end
                chk("m_gnt", gnt, e_gnt);
                chk("m_wren", mem_wren, e_wren);
                chk("m_addr", mem_address, e_addr);
                chk("m_data", mem_data, e_data);
                chk("m_rvalid", rvalid, e_rv);
                chk("m_lockerr", lock_err, m_err);
                if (e_rv != 0) chk("m_rdata", rdata, e_rd);
                if (g >= 0) begin
                    $display("cyc %0d: req%0d %s addr=%02h data=%02h", cyc, g,
                             we[g] ? "WR" : "RD", e_addr, e_data);
                    if (we[g]) ref_mem[e_addr] = e_data;
                    else begin
                        rv_tab[(cyc + RD_LAT) % 16] = e_gnt;
                        rd_tab[(cyc + RD_LAT) % 16] = ref_mem[e_addr];
                    end
                end
                for (int k = 0; k < NREQ; k++) if (!lock[k]) m_banned[k] = 1'b0;
                if (m_owner < 0) begin
                    if (g >= 0) begin
                        m_rr = (g + 1) % NREQ;
                        if (lock[g] && !m_banned[g]) begin m_owner = g; m_held = 0; end
                    end
                end else if (!lock[m_owner]) begin
                    m_owner = -1;
                end else begin
                    m_held++;
                    if (m_held >= LOCK_MAX) begin
                        m_banned[m_owner] = 1'b1;
                        m_err   = 1'b1;
                        m_owner = -1;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus with literal expectations ---------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i]    = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        reset = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) tick();
        settle();
        chk("rst_gnt", gnt, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_lockerr", lock_err, 0);

        // 1: all three read, round-robin order 0,1,2,0
        tick(); reset = 1'b0; req = 3'b111;
        addr[7:0] = 8'h0A; addr[15:8] = 8'h0B; addr[23:16] = 8'h0C;
        settle(); chk("t1_gnt0", gnt, 3'b001); chk("t1_rv0", rvalid, 3'b000);
        tick(); settle(); chk("t1_gnt1", gnt, 3'b010); chk("t1_rv1", rvalid, 3'b001);
        chk("t1_rd1", rdata, 8'hAF);
        tick(); settle(); chk("t1_gnt2", gnt, 3'b100); chk("t1_rv2", rvalid, 3'b010);
        chk("t1_rd2", rdata, 8'hAE);
        tick(); settle(); chk("t1_gnt3", gnt, 3'b001); chk("t1_rv3", rvalid, 3'b100);
        chk("t1_rd3", rdata, 8'hA9);
        tick(); req = 3'b000;
        settle(); chk("t1_gnt4", gnt, 3'b000); chk("t1_rv4", rvalid, 3'b001);

        // 2: read, write 0x5A, read back address 0x05
        tick(); req = 3'b001; we = 3'b000; addr[7:0] = 8'h05;
        settle(); chk("t2_gnt_r", gnt, 3'b001); chk("t2_addr", mem_address, 8'h05);
        chk("t2_wren_r", mem_wren, 0);
        tick(); we = 3'b001; wdata[7:0] = 8'h5A;
        settle(); chk("t2_wren_w", mem_wren, 1); chk("t2_data_w", mem_data, 8'h5A);
        chk("t2_rv_old", rvalid, 3'b001); chk("t2_rd_old", rdata, 8'hA0);
        tick(); we = 3'b000;
        settle(); chk("t2_wren_r2", mem_wren, 0); chk("t2_rv_w", rvalid, 3'b000);
        tick(); req = 3'b000;
        settle(); chk("t2_rv_new", rvalid, 3'b001); chk("t2_rd_new", rdata, 8'h5A);

        // 3: requester 1 locks for four accesses, then releases
        tick(); req = 3'b111; lock = 3'b010; addr[15:8] = 8'h30;
        settle(); chk("t3_gnt_lock", gnt, 3'b010);
        for (int i = 1; i < 4; i++) begin
            tick(); settle(); chk("t3_gnt_own", gnt, 3'b010);
        end
        tick(); lock = 3'b000;
        settle(); chk("t3_gnt_drop", gnt, 3'b000);
        tick(); settle(); chk("t3_gnt_next", gnt, 3'b100);

        // 4: requester 2 overholds the lock and gets evicted
        tick(); req = 3'b100; lock = 3'b100; addr[23:16] = 8'h44;
        settle(); chk("t4_gnt_lock", gnt, 3'b100);
        for (int i = 2; i <= 65; i++) begin
            tick(); req = 3'b101;
            if (i == 65) begin
                settle(); chk("t4_gnt_last", gnt, 3'b100); chk("t4_err_pre", lock_err, 0);
            end
        end
        tick(); settle(); chk("t4_gnt_evict", gnt, 3'b001); chk("t4_err", lock_err, 1);
        tick(); settle(); chk("t4_gnt_plain", gnt, 3'b100);
        tick(); settle(); chk("t4_gnt_nolock", gnt, 3'b001);
        tick(); tick();
        tick(); req = 3'b100; lock = 3'b000;
        settle(); chk("t4_gnt_rel", gnt, 3'b100);
        tick(); lock = 3'b100;
        settle(); chk("t4_gnt_relock", gnt, 3'b100);
        tick(); req = 3'b101;
        settle(); chk("t4_gnt_owned", gnt, 3'b100);
        tick(); lock = 3'b000;
        settle(); chk("t4_gnt_drop", gnt, 3'b000);

        // 6: owner pauses its requests while keeping the lock
        tick(); req = 3'b010; lock = 3'b010; addr[15:8] = 8'h40;
        settle(); chk("t6_gnt_lock", gnt, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick(); req = 3'b101; we = 3'b111;
            settle(); chk("t6_gnt_stall", gnt, 3'b000); chk("t6_wren_stall", mem_wren, 0);
        end
        tick(); req = 3'b111; we = 3'b010; wdata[15:8] = 8'h33;
        settle(); chk("t6_gnt_wr", gnt, 3'b010); chk("t6_wren_wr", mem_wren, 1);
        tick(); lock = 3'b000; we = 3'b000;
        settle(); chk("t6_gnt_drop", gnt, 3'b000);
        tick(); settle(); chk("t6_gnt_resume", gnt, 3'b100);
        tick(); req = 3'b001; addr[7:0] = 8'h40;
        settle(); chk("t6_gnt_rb", gnt, 3'b001);
        tick(); req = 3'b000;
        settle(); chk("t6_rv_rb", rvalid, 3'b001); chk("t6_rd_rb", rdata, 8'h33);

        // 5: reset right after a read grant
        tick(); req = 3'b001; addr[7:0] = 8'h20;
        settle(); chk("t5_gnt_rd", gnt, 3'b001);
        tick(); reset = 1'b1; req = 3'b000;
        settle(); chk("t5_rv_rst", rvalid, 3'b000); chk("t5_err_rst", lock_err, 0);
        chk("t5_gnt_rst", gnt, 3'b000);
        tick(); req = 3'b111;
        settle(); chk("t5_gnt_rst2", gnt, 3'b000); chk("t5_addr_rst", mem_address, 8'h00);
        tick(); reset = 1'b0;
        settle(); chk("t5_gnt_post", gnt, 3'b001); chk("t5_rv_post", rvalid, 3'b000);
        chk("t5_err_post", lock_err, 0);
        tick(); req = 3'b000;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
